// File: rtl/program_counter.sv
// Program counter for a simple sequencer: fetch address, branch, halt and
// retired-instruction count, sequenced by an IDLE/RUN/DONE state machine.
module program_counter #(
   parameter int unsigned PC_W       = 10,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned START_ADDR = 0
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Halt,
   input  logic             Branch,
   input  logic             Zero,
   input  logic [7:0]       Offset,
   output logic [PC_W-1:0]  PC,
   output logic             Done,
   output logic [CNT_W-1:0] InstCount
);

   localparam int unsigned ST_W = 2;

   localparam logic [ST_W-1:0] S_IDLE = 2'd0;
   localparam logic [ST_W-1:0] S_RUN  = 2'd1;
   localparam logic [ST_W-1:0] S_DONE = 2'd2;

   localparam logic [PC_W-1:0]  PC_START = PC_W'(START_ADDR);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [ST_W-1:0]  state_q, state_nxt;
   logic [PC_W-1:0]  pc_q, pc_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             done_q;

   logic             take_branch;
   logic [PC_W-1:0]  offset_ext;
   logic [CNT_W-1:0] cnt_inc;

   // Branch decode, sign-extended displacement and saturating count step
   always_comb begin
      take_branch = Branch & Zero;
      offset_ext  = PC_W'($signed(Offset));
      cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
   end

   // State register; all architectural state resets asynchronously
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= PC_START;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         pc_q    <= pc_nxt;
         cnt_q   <= cnt_nxt;
         done_q  <= (state_nxt == S_DONE);
      end
   end

   // Next-state, next-PC and next-count; halt outranks a taken branch
   always_comb begin
      state_nxt = state_q;
      pc_nxt    = pc_q;
      cnt_nxt   = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            pc_nxt  = PC_START;
            cnt_nxt = '0;
            if (Start) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            cnt_nxt = cnt_inc;
            if (Halt) begin
               state_nxt = S_DONE;
            end else if (take_branch) begin
               pc_nxt = pc_q + offset_ext;
            end else begin
               pc_nxt = pc_q + PC_W'(1);
            end
         end
         S_DONE: begin
            if (Start) begin
               state_nxt = S_RUN;
               pc_nxt    = PC_START;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_IDLE;
            pc_nxt    = PC_START;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs come straight from registers
   always_comb begin
      PC        = pc_q;
      Done      = done_q;
      InstCount = cnt_q;
   end

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: vector table for the main sequence
// plus hand-written reset and counter-saturation sequences.
module tb_program_counter;

   logic        CLK = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Reset4_n = 1'b0;
   logic        Start = 1'b0;
   logic        Halt = 1'b0;
   logic        Branch = 1'b0;
   logic        Zero = 1'b0;
   logic [7:0]  Offset = 8'h00;
   logic [9:0]  PC;
   logic        Done;
   logic [15:0] InstCount;
   logic [9:0]  pc4;
   logic        done4;
   logic [3:0]  cnt4;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       start;
      logic       halt;
      logic       branch;
      logic       zero;
      logic [7:0] offset;
      int         exp_pc;
      int         exp_done;
      int         exp_cnt;
   } vec_t;

   vec_t vecs[$];

   program_counter #(.PC_W(10), .CNT_W(16), .START_ADDR(0)) dut (
      .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .Halt(Halt),
      .Branch(Branch), .Zero(Zero), .Offset(Offset),
      .PC(PC), .Done(Done), .InstCount(InstCount)
   );

   program_counter #(.PC_W(10), .CNT_W(4), .START_ADDR(0)) dut4 (
      .CLK(CLK), .Reset_n(Reset4_n), .Start(Start), .Halt(Halt),
      .Branch(Branch), .Zero(Zero), .Offset(Offset),
      .PC(pc4), .Done(done4), .InstCount(cnt4)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_main(input string tag, input int pc, input int dn, input int cnt);
      check({tag, " PC"}, int'(PC), pc);
      check({tag, " Done"}, int'(Done), dn);
      check({tag, " InstCount"}, int'(InstCount), cnt);
   endtask

   task automatic drive(input logic s, input logic h, input logic b,
                        input logic z, input logic [7:0] o);
      Start  = s;
      Halt   = h;
      Branch = b;
      Zero   = z;
      Offset = o;
   endtask

   initial begin
      // start halt branch zero offset | pc done cnt
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,    0, 0,  0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    1, 0,  1});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    2, 0,  2});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    3, 0,  3});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,    4, 0,  4});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 8'hFD,    5, 0,  5});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'hFD,    2, 0,  6});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h03,    5, 0,  7});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 8'hFD,    6, 0,  8});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h00,    6, 0,  9});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    7, 0, 10});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'hF8, 1023, 0, 11});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    0, 0, 12});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    1, 0, 13});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'hFE, 1023, 0, 14});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    0, 0, 15});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h07,    7, 0, 16});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 8'hFD,    7, 1, 17});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    7, 1, 17});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 8'h05,    7, 1, 17});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 8'h00,    0, 0,  0});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 8'h00,    1, 0,  1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 8'h0B,   12, 0,  2});

      // Reset values while held in reset
      #3;
      check_main("reset", 0, 0, 0);

      // IDLE ignores Halt/Branch/Zero/Offset
      @(negedge CLK);
      Reset_n = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h10);
      @(posedge CLK); #1;
      check_main("idle ignore", 0, 0, 0);

      // Main table
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge CLK);
         drive(vecs[i].start, vecs[i].halt, vecs[i].branch, vecs[i].zero, vecs[i].offset);
         @(posedge CLK); #1;
         check_main($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_done, vecs[i].exp_cnt);
      end

      // Asynchronous reset between edges mid-RUN at PC=12
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      #2 Reset_n = 1'b0;
      #1;
      check_main("async rst", 0, 0, 0);
      @(negedge CLK);
      Reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         check_main($sformatf("post rst idle%0d", i), 0, 0, 0);
      end

      // Start at the first edge after reset release enters RUN immediately
      @(negedge CLK);
      Reset_n = 1'b0;
      Start   = 1'b1;
      #2 Reset_n = 1'b1;
      @(posedge CLK); #1;
      check_main("start after rst", 0, 0, 0);
      @(negedge CLK);
      Start = 1'b0;
      @(posedge CLK); #1;
      check_main("run after rst", 1, 0, 1);

      // Saturating counter on the narrow-count instance
      @(negedge CLK);
      Reset4_n = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge CLK); #1;
      check("sat start cnt", int'(cnt4), 0);
      @(negedge CLK);
      Start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLK); #1;
         check($sformatf("sat cnt%0d", i), int'(cnt4), (i > 15) ? 15 : i);
      end
      check("sat pc", int'(pc4), 20);
      check("sat done", int'(done4), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/program_counter.md
PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The module SHALL have parameter PC_W, default 10, giving the width of the instruction address.
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the width of the executed-instruction counter.
REQ-003 The module SHALL have parameter START_ADDR, default 0, giving the first fetch address after reset or restart.
REQ-004 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The module SHALL have port Start, input, 1 bit: begin or restart execution.
REQ-007 The module SHALL have port Halt, input, 1 bit: the decoded halt instruction for the current PC.
REQ-008 The module SHALL have port Branch, input, 1 bit: the current instruction is beq.
REQ-009 The module SHALL have port Zero, input, 1 bit: the ALU Zero flag for the current instruction.
REQ-010 The module SHALL have port Offset, input, 8 bits: signed two's-complement branch displacement.
REQ-011 The module SHALL have port PC, output, PC_W bits: the current instruction address, registered.
REQ-012 The module SHALL have port Done, output, 1 bit: the program has halted, registered.
REQ-013 The module SHALL have port InstCount, output, CNT_W bits: the number of instructions retired since the last start, registered.

Function
REQ-014 The module SHALL implement three states: IDLE, RUN and DONE.
REQ-015 In IDLE, PC SHALL hold START_ADDR, Done SHALL be 0 and InstCount SHALL hold 0; Halt, Branch, Zero and Offset SHALL be ignored.
REQ-016 In IDLE, Start=1 at a rising edge SHALL move the state to RUN with PC unchanged, so that the first instruction is fetched at START_ADDR.
REQ-017 In RUN, each rising edge SHALL retire one instruction, applying the first matching rule of REQ-018 to REQ-020.
REQ-018 Halt=1 SHALL move the state to DONE, hold PC and increment InstCount; this priority applies even when Branch=1 and Zero=1 in the same cycle.
REQ-019 Branch=1 and Zero=1 SHALL set PC to PC + sign-extended Offset, modulo 2^PC_W; Offset=0 is legal and holds PC as a self-loop.
REQ-020 Otherwise PC SHALL be set to PC+1, modulo 2^PC_W, so that 2^PC_W-1 wraps to 0.
REQ-021 Zero SHALL be ignored whenever Branch=0.
REQ-022 InstCount SHALL increment once per RUN cycle and saturate at 2^CNT_W-1 without wrapping.
REQ-023 Start SHALL be ignored while in RUN.
REQ-024 Done SHALL be 1 exactly while in DONE, first asserting in the cycle after the halting edge.
REQ-025 In DONE, PC and InstCount SHALL hold their values and Halt, Branch and Zero SHALL be ignored.
REQ-026 In DONE, Start=1 SHALL move the state to RUN, set PC to START_ADDR, set InstCount to 0 and clear Done, all at the same edge.
REQ-027 Outputs SHALL depend only on registered state, with no combinational path from any input to any output.

Reset
REQ-028 Reset_n=0 SHALL immediately, without waiting for a clock edge, set the state to IDLE, PC to START_ADDR, InstCount to 0 and Done to 0.
REQ-029 Asserting Reset_n=0 in any state, including mid-RUN, SHALL abandon execution with no further PC update.
REQ-030 With Start=1 at the first rising edge after Reset_n deasserts, the module SHALL enter RUN at that edge.

Verification
REQ-031 The bench SHALL cover: reset, Start pulse, 3 RUN cycles with Branch=0 -> PC 0,1,2,3 and InstCount 3, Done=0.
REQ-032 The bench SHALL cover: at PC=5, Branch=1, Zero=1, Offset=8'hFD -> next PC=2; the same with Zero=0 -> next PC=6.
REQ-033 The bench SHALL cover: PC=1023 with Branch=0 -> PC=0; PC=1 with Branch=1, Zero=1, Offset=8'hFE -> PC=1023.
REQ-034 The bench SHALL cover: Halt=1, Branch=1 and Zero=1 at PC=7 -> PC stays 7, Done=1 next cycle, InstCount stops; then Start=1 -> PC=0, InstCount=0, Done=0, state RUN.
REQ-035 The bench SHALL cover: Reset_n pulsed low between clock edges mid-RUN at PC=12 -> PC=0, Done=0 and InstCount=0 before the next edge; Start=0 thereafter -> PC holds 0.
REQ-036 The bench SHALL cover: CNT_W=4 with 20 RUN cycles -> InstCount saturates at 15.
